// File: rtl/dog_pair_scheduler.sv
// Time-shares one DoG subtractor across the NUM_SCALES-1 adjacent scale pairs of a pixel column
// and tags each subtractor result with its scale index and pixel position.
module dog_pair_scheduler #(
  parameter int unsigned NUM_SCALES = 5,
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480,
  parameter int unsigned DOG_LAT    = 2,
  localparam int unsigned KW = (NUM_SCALES > 2) ? $clog2(NUM_SCALES - 1) : 1,
  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic                    clk,
  input  logic                    irst_n,
  input  logic                    ivalid,
  input  logic [9*NUM_SCALES-1:0] idata,
  output logic                    oready,
  output logic [8:0]              oa,
  output logic [8:0]              ob,
  output logic                    ovalid,
  output logic [KW-1:0]           oscale,
  output logic [XW-1:0]           ox,
  output logic [YW-1:0]           oy,
  output logic                    oframe_done
);

  localparam logic [KW-1:0] KLAST = KW'(NUM_SCALES - 2);
  localparam logic [XW-1:0] XLAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YLAST = YW'(IMG_H - 1);
  // Stage 0 is aligned with oa/ob; DOG_LAT further stages match the subtractor.
  localparam int unsigned NSTG = DOG_LAT + 1;

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e                  r_state, w_state_d;
  logic [KW-1:0]           r_k, w_k_d;
  logic [9*NUM_SCALES-1:0] r_col;
  logic [XW-1:0]           r_x, w_x_d;
  logic [YW-1:0]           r_y, w_y_d;
  logic                    r_first;
  logic [8:0]              r_oa, r_ob, w_a, w_b;
  logic                    w_accept, w_issue, w_klast, w_last;

  logic [NSTG-1:0]         r_tv, r_tl;
  logic [KW-1:0]           r_tk [NSTG];
  logic [XW-1:0]           r_tx [NSTG];
  logic [YW-1:0]           r_ty [NSTG];

  assign w_issue  = (r_state == StIssue);
  assign w_klast  = (r_k == KLAST);
  assign oready   = (r_state == StIdle) | (w_issue & w_klast);
  assign w_accept = ivalid & oready;
  assign w_last   = w_issue & w_klast & (r_x == XLAST) & (r_y == YLAST);

  always_comb begin
    w_state_d = r_state;
    w_k_d     = r_k;
    if (w_accept) begin
      w_state_d = StIssue;
      w_k_d     = '0;
    end else if (w_issue) begin
      if (w_klast) begin
        w_state_d = StIdle;
        w_k_d     = '0;
      end else begin
        w_k_d = r_k + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      r_state <= StIdle;
      r_k     <= '0;
    end else begin
      r_state <= w_state_d;
      r_k     <= w_k_d;
    end
  end

  // Scale-0 SOF resyncs the position; the first column after reset is always (0,0).
  always_comb begin
    w_x_d = r_x;
    w_y_d = r_y;
    if (w_accept) begin
      if (r_first | idata[8]) begin
        w_x_d = '0;
        w_y_d = '0;
      end else if (r_x == XLAST) begin
        w_x_d = '0;
        w_y_d = (r_y == YLAST) ? '0 : r_y + 1'b1;
      end else begin
        w_x_d = r_x + 1'b1;
      end
    end
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int unsigned i = 0; i < NUM_SCALES - 1; i++) begin
      if (r_k == KW'(i)) begin
        w_a = r_col[9*i +: 9];
        w_b = r_col[9*(i+1) +: 9];
      end
    end
  end

  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      r_col   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_first <= 1'b1;
      r_oa    <= '0;
      r_ob    <= '0;
    end else begin
      r_x <= w_x_d;
      r_y <= w_y_d;
      if (w_accept) begin
        r_col   <= idata;
        r_first <= 1'b0;
      end
      if (w_issue) begin
        r_oa <= w_a;
        r_ob <= w_b;
      end
    end
  end

  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      r_tv <= '0;
      r_tl <= '0;
      for (int i = 0; i < NSTG; i++) begin
        r_tk[i] <= '0;
        r_tx[i] <= '0;
        r_ty[i] <= '0;
      end
    end else begin
      r_tv    <= {r_tv[NSTG-2:0], w_issue};
      r_tl    <= {r_tl[NSTG-2:0], w_last};
      r_tk[0] <= w_issue ? r_k : '0;
      r_tx[0] <= w_issue ? r_x : '0;
      r_ty[0] <= w_issue ? r_y : '0;
      for (int i = 1; i < NSTG; i++) begin
        r_tk[i] <= r_tk[i-1];
        r_tx[i] <= r_tx[i-1];
        r_ty[i] <= r_ty[i-1];
      end
    end
  end

  assign oa          = r_oa;
  assign ob          = r_ob;
  assign ovalid      = r_tv[DOG_LAT];
  assign oframe_done = r_tl[DOG_LAT];
  assign oscale      = r_tk[DOG_LAT];
  assign ox          = r_tx[DOG_LAT];
  assign oy          = r_ty[DOG_LAT];

endmodule

// File: tb/tb_dog_pair_scheduler.sv
// Bench for dog_pair_scheduler: directed and random columns checked against a queue-based model
// of pair issue order, subtractor latency and pixel position.
module tb_dog_pair_scheduler;
  localparam int NS  = 5;
  localparam int W   = 4;
  localparam int H   = 2;
  localparam int LAT = 2;
  localparam int DW  = 9 * NS;

  logic          clk = 1'b0;
  logic          irst_n = 1'b0;
  logic          ivalid = 1'b0;
  logic [DW-1:0] idata = '0;
  logic          oready, ovalid, oframe_done;
  logic [8:0]    oa, ob;
  logic [1:0]    oscale;
  logic [1:0]    ox;
  logic [0:0]    oy;

  dog_pair_scheduler #(
    .NUM_SCALES(NS),
    .IMG_W     (W),
    .IMG_H     (H),
    .DOG_LAT   (LAT)
  ) dut (
    .clk        (clk),
    .irst_n     (irst_n),
    .ivalid     (ivalid),
    .idata      (idata),
    .oready     (oready),
    .oa         (oa),
    .ob         (ob),
    .ovalid     (ovalid),
    .oscale     (oscale),
    .ox         (ox),
    .oy         (oy),
    .oframe_done(oframe_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int k;
    int x;
    int y;
    bit last;
  } tag_t;

  typedef struct {
    logic [8:0] a;
    logic [8:0] b;
    tag_t       t;
  } pair_t;

  pair_t      pairq[$];
  tag_t       tagq[$];
  logic [8:0] exp_a, exp_b;
  int         mx, my;
  bit         mfirst;
  int         tests = 0;
  int         fails = 0;

  function automatic tag_t no_tag();
    tag_t t;
    t.v = 0; t.k = 0; t.x = 0; t.y = 0; t.last = 0;
    return t;
  endfunction

  task automatic model_reset();
    pairq.delete();
    tagq.delete();
    for (int i = 0; i <= LAT; i++) tagq.push_back(no_tag());
    exp_a  = '0;
    exp_b  = '0;
    mx     = 0;
    my     = 0;
    mfirst = 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic enqueue(input logic [DW-1:0] d);
    pair_t p;
    if (mfirst || d[8]) begin
      mx = 0;
      my = 0;
    end else begin
      mx++;
      if (mx == W) begin
        mx = 0;
        my = (my == H - 1) ? 0 : my + 1;
      end
    end
    mfirst = 0;
    for (int k = 0; k < NS - 1; k++) begin
      p.a      = d[9*k +: 9];
      p.b      = d[9*(k+1) +: 9];
      p.t.v    = 1;
      p.t.k    = k;
      p.t.x    = mx;
      p.t.y    = my;
      p.t.last = (k == NS - 2) && (mx == W - 1) && (my == H - 1);
      pairq.push_back(p);
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step(input bit v, input logic [DW-1:0] d, output bit acc);
    tag_t  t;
    pair_t p;
    ivalid = v;
    idata  = d;
    #1;
    chk("oready", 32'(oready), 32'(pairq.size() <= 1));
    acc = v && (pairq.size() <= 1);
    @(posedge clk);
    t = no_tag();
    if (pairq.size() > 0) begin
      p     = pairq.pop_front();
      exp_a = p.a;
      exp_b = p.b;
      t     = p.t;
    end
    tagq.push_back(t);
    void'(tagq.pop_front());
    if (acc) enqueue(d);
    t = tagq[0];
    #1;
    chk("oa", 32'(oa), 32'(exp_a));
    chk("ob", 32'(ob), 32'(exp_b));
    chk("ovalid", 32'(ovalid), 32'(t.v));
    chk("oframe_done", 32'(oframe_done), 32'(t.last));
    if (t.v) begin
      chk("oscale", 32'(oscale), 32'(t.k));
      chk("ox", 32'(ox), 32'(t.x));
      chk("oy", 32'(oy), 32'(t.y));
    end
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] mkcol(input bit sof);
    logic [DW-1:0] c;
    logic [8:0]    w;
    for (int s = 0; s < NS; s++) begin
      w = 9'($urandom);
      if (s == 0) w[8] = sof;
      c[9*s +: 9] = w;
    end
    return c;
  endfunction

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, '0, acc);
  endtask

  task automatic stream(input int n, input int sof_at);
    logic [DW-1:0] d;
    bit            acc;
    for (int c = 0; c < n; c++) begin
      d   = mkcol(c == sof_at);
      acc = 0;
      while (!acc) step(1, d, acc);
    end
  endtask

  initial begin
    logic [DW-1:0] d;
    bit            acc;
    bit            pend;

    model_reset();
    #12;
    chk("rst_oa", 32'(oa), 0);
    chk("rst_ob", 32'(ob), 0);
    chk("rst_ovalid", 32'(ovalid), 0);
    chk("rst_oscale", 32'(oscale), 0);
    chk("rst_ox", 32'(ox), 0);
    chk("rst_oy", 32'(oy), 0);
    chk("rst_oframe_done", 32'(oframe_done), 0);
    chk("rst_oready", 32'(oready), 1);
    @(negedge clk);
    irst_n = 1'b1;

    // Single column 100,80,60,40,20 with SOF on scale 0.
    d = {9'd20, 9'd40, 9'd60, 9'd80, 9'(256 + 100)};
    step(1, d, acc);
    chk("first_accept", 32'(acc), 1);
    idle(7);

    // Back-to-back columns across a frame wrap, ivalid held during issue.
    stream(12, -1);
    idle(6);

    // SOF on the third column of a partial frame.
    stream(5, 2);
    idle(6);

    // Asynchronous reset while pair k=2 is pending.
    step(1, mkcol(0), acc);
    chk("pre_rst_accept", 32'(acc), 1);
    idle(2);
    #2;
    irst_n = 1'b0;
    #1;
    chk("arst_oa", 32'(oa), 0);
    chk("arst_ob", 32'(ob), 0);
    chk("arst_ovalid", 32'(ovalid), 0);
    chk("arst_oscale", 32'(oscale), 0);
    chk("arst_ox", 32'(ox), 0);
    chk("arst_oy", 32'(oy), 0);
    chk("arst_oframe_done", 32'(oframe_done), 0);
    chk("arst_oready", 32'(oready), 1);
    model_reset();
    @(negedge clk);
    irst_n = 1'b1;
    idle(8);
    stream(3, -1);

    // Random traffic; upstream holds data until it is taken.
    pend = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        d    = mkcol(($urandom % 10) == 0);
        pend = 1;
      end
      step(($urandom % 4) != 0, d, acc);
      if (acc) pend = 0;
    end
    idle(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
